// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encodings,
// requester ids and the default memory depth.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic REQ_R0 = 1'b0;
  localparam logic REQ_R1 = 1'b1;

  localparam int DEFAULT_DEPTH = 1024;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker. Purely combinational; the caller owns the
// 'last' register and updates it on every grant.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  // Sole requester wins outright; on a tie the one that did not win last time wins.
  always_comb begin
    valid  = |req;
    winner = REQ_R0;
    if (req == 2'b11) begin
      winner = ~last;
    end else if (req[1]) begin
      winner = REQ_R1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the shared-bus data memory.
// One transaction in flight: IDLE (arbitrate + latch) -> ACCESS (one memory
// cycle) -> DONE (ack to winner) -> IDLE. Out-of-range addresses skip ACCESS.
//
// Handshake: a requester raises rN_req with we/addr/wdata stable and holds
// them until it sees rN_ack high at a rising edge; ack is a one-cycle pulse
// and rN_rdata/rN_err are only meaningful while it is high. Request changes
// after the grant are ignored: the latched transaction always completes.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_err,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_err,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data,
  output state_t            dbg_state
);

  state_t              state_q, state_d;
  logic                last_q;
  logic                win_q;
  logic                we_q;
  logic                err_q;
  logic                mem_rw_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                pick_valid;
  logic                pick_id;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                in_range;
  logic                grant;
  logic                done;

  rr_pick2 u_pick (
    .req    ({r1_req, r0_req}),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_id)
  );

  // Mux the winning requester's transaction and range-check its address.
  always_comb begin
    sel_we    = (pick_id == REQ_R1) ? r1_we    : r0_we;
    sel_addr  = (pick_id == REQ_R1) ? r1_addr  : r0_addr;
    sel_wdata = (pick_id == REQ_R1) ? r1_wdata : r0_wdata;
    in_range  = (sel_addr < ADDR_W'(DEPTH));
    grant     = (state_q == ST_IDLE) && pick_valid;
  end

  // Next-state logic: errors go straight to DONE without touching memory.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (pick_valid) state_d = in_range ? ST_ACCESS : ST_DONE;
      ST_ACCESS: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Holding registers, round-robin pointer, registered mem_rw and read capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q   <= REQ_R1;
      win_q    <= REQ_R0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      mem_rw_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else if (grant) begin
      last_q   <= pick_id;
      win_q    <= pick_id;
      we_q     <= sel_we;
      err_q    <= ~in_range;
      mem_rw_q <= in_range & sel_we;
      addr_q   <= sel_addr;
      wdata_q  <= sel_wdata;
      rdata_q  <= '0;
    end else if (state_q == ST_ACCESS) begin
      mem_rw_q <= 1'b0;
      if (!we_q) begin
        rdata_q <= mem_data;
      end
    end
  end

  // Memory side: bus driven only while the registered write strobe is high.
  assign mem_rw    = mem_rw_q;
  assign mem_addr  = addr_q;
  assign mem_data  = mem_rw_q ? wdata_q : {DATA_W{1'bz}};
  assign dbg_state = state_q;

  // Requester side: only the recorded winner sees ack/err/rdata in DONE.
  always_comb begin
    done     = (state_q == ST_DONE);
    r0_ack   = done && (win_q == REQ_R0);
    r1_ack   = done && (win_q == REQ_R1);
    r0_err   = r0_ack & err_q;
    r1_err   = r1_ack & err_q;
    r0_rdata = r0_ack ? rdata_q : '0;
    r1_rdata = r1_ack ? rdata_q : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural shared-bus memory, table of single
// transactions, plus hand-written multi-cycle sequences.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int DW = 64;
  localparam int AW = 64;

  typedef struct {
    logic          who;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          r0_req = 1'b0, r1_req = 1'b0, r0_we = 1'b0, r1_we = 1'b0;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0;
  logic [DW-1:0] r0_wdata = '0, r1_wdata = '0;
  logic          r0_ack, r1_ack, r0_err, r1_err, mem_rw;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;
  state_t        dbg_state;

  logic [DW-1:0] dm [0:1023];
  logic          mem_drive_en = 1'b1;
  logic          watch_bus = 1'b0;
  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_q [$];
  vec_t          vecs [11];

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_data(mem_data),
    .dbg_state(dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Memory model: drives the bus on reads, writes on the falling edge.
  assign mem_data = (!mem_rw && mem_drive_en) ? dm[mem_addr[9:0]] : {DW{1'bz}};
  always @(negedge clk) if (mem_rw) dm[mem_addr[9:0]] <= mem_data;

  function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // With the memory silenced, the bus must be released whenever mem_rw is low.
  always @(negedge clk) begin
    if (watch_bus && !mem_rw)
      chk("bus_released", {63'b0, (mem_data === {DW{1'bz}}) || (mem_data === '0)}, 64'd1);
  end

  task automatic apply_reset();
    r0_req = 0; r1_req = 0;
    rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
  endtask

  // Runs one transaction; caller is at a falling edge with the DUT idle.
  task automatic run_vec(input int idx, input vec_t v);
    int  lat = 0;
    logic seen = 0;
    if (v.who == REQ_R0) begin
      r0_req = 1; r0_we = v.we; r0_addr = v.addr; r0_wdata = v.wdata;
    end else begin
      r1_req = 1; r1_we = v.we; r1_addr = v.addr; r1_wdata = v.wdata;
    end
    for (int k = 1; k <= 8 && !seen; k++) begin
      @(negedge clk);
      if (v.exp_err) chk($sformatf("v%0d_err_no_mem_rw", idx), {63'b0, mem_rw}, 64'd0);
      chk($sformatf("v%0d_loser_ack", idx), {63'b0, (v.who == REQ_R0) ? r1_ack : r0_ack}, 64'd0);
      if (((v.who == REQ_R0) ? r0_ack : r1_ack) === 1'b1) begin
        seen = 1;
        lat = k;
      end
    end
    if (!seen) begin
      chk($sformatf("v%0d_ack_timeout", idx), 64'd0, 64'd1);
    end else begin
      chk($sformatf("v%0d_latency", idx), 64'(lat), v.exp_err ? 64'd1 : 64'd2);
      chk($sformatf("v%0d_err", idx), {63'b0, (v.who == REQ_R0) ? r0_err : r1_err}, {63'b0, v.exp_err});
      chk($sformatf("v%0d_rdata", idx), (v.who == REQ_R0) ? r0_rdata : r1_rdata, v.exp_rdata);
      chk($sformatf("v%0d_loser_rdata", idx), (v.who == REQ_R0) ? r1_rdata : r0_rdata, '0);
    end
    r0_req = 0; r1_req = 0;
    @(negedge clk);
    chk($sformatf("v%0d_ack_single", idx), {62'b0, r1_ack, r0_ack}, 64'd0);
  endtask

  initial begin
    int got;
    int n0;
    int n1;
    logic first;

    for (int i = 0; i < 1024; i++) dm[i] = '0;
    dm[0]  = 64'h1111_2222_3333_4444;
    dm[1]  = 64'hA5A5_A5A5_5A5A_5A5A;
    dm[2]  = 64'h0BAD_F00D_0000_0002;
    dm[3]  = 64'h3333_0000_3333_0003;
    dm[7]  = 64'h7777_0000_7777_0007;
    dm[9]  = 64'h9999_0000_9999_0009;

    vecs[0]  = '{REQ_R0, 1, 64'd5,    64'hDEAD_BEEF_0000_0001, 0, 64'h0};
    vecs[1]  = '{REQ_R0, 0, 64'd5,    64'h0,                   0, 64'hDEAD_BEEF_0000_0001};
    vecs[2]  = '{REQ_R1, 1, 64'd1023, 64'h0123_4567_89AB_CDEF, 0, 64'h0};
    vecs[3]  = '{REQ_R1, 0, 64'd1023, 64'h0,                   0, 64'h0123_4567_89AB_CDEF};
    vecs[4]  = '{REQ_R1, 1, 64'd1024, 64'hCAFE_CAFE_CAFE_CAFE, 1, 64'h0};
    vecs[5]  = '{REQ_R0, 0, 64'd1024, 64'h0,                   1, 64'h0};
    vecs[6]  = '{REQ_R0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,    1, 64'h0};
    vecs[7]  = '{REQ_R1, 0, 64'd0,    64'h0,                   0, 64'h1111_2222_3333_4444};
    vecs[8]  = '{REQ_R0, 0, 64'd1,    64'h0,                   0, 64'hA5A5_A5A5_5A5A_5A5A};
    vecs[9]  = '{REQ_R0, 1, 64'd1023, 64'hFEDC_BA98_7654_3210, 0, 64'h0};
    vecs[10] = '{REQ_R1, 0, 64'd1023, 64'h0,                   0, 64'hFEDC_BA98_7654_3210};

    // Reset state, checked while reset is held.
    @(negedge clk);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("rst_acks", {60'b0, r1_err, r0_err, r1_ack, r0_ack}, 64'd0);
    chk("rst_mem_rw", {63'b0, mem_rw}, 64'd0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_rdata", r0_rdata | r1_rdata, '0);
    rst = 1;
    @(negedge clk);

    // Table of single transactions.
    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);
    chk("oor_write_dm0_intact", dm[0], 64'h1111_2222_3333_4444);

    // Simultaneous reads after reset: r0 first, r1 three cycles later.
    apply_reset();
    r0_req = 1; r0_we = 0; r0_addr = 64'd3;
    r1_req = 1; r1_we = 0; r1_addr = 64'd7;
    @(negedge clk);
    chk("sim_no_ack_access", {62'b0, r1_ack, r0_ack}, 64'd0);
    @(negedge clk);
    chk("sim_r0_ack", {63'b0, r0_ack}, 64'd1);
    chk("sim_r0_rdata", r0_rdata, 64'h3333_0000_3333_0003);
    chk("sim_r1_quiet", {63'b0, r1_ack | r1_err}, 64'd0);
    chk("sim_r1_rdata_zero", r1_rdata, '0);
    r0_req = 0;
    repeat (2) @(negedge clk);
    chk("sim_r1_not_yet", {62'b0, r1_ack, r0_ack}, 64'd0);
    @(negedge clk);
    chk("sim_r1_ack", {63'b0, r1_ack}, 64'd1);
    chk("sim_r1_rdata", r1_rdata, 64'h7777_0000_7777_0007);
    chk("sim_r0_quiet", {63'b0, r0_ack | r0_err}, 64'd0);
    chk("sim_r0_rdata_zero", r0_rdata, '0);
    r1_req = 0;
    @(negedge clk);

    // Fairness: both hold req for six back-to-back writes.
    apply_reset();
    mem_drive_en = 0;
    watch_bus = 1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(64'd0);
      exp_q.push_back(64'd1);
    end
    n0 = 1; n1 = 1; got = 0;
    r0_req = 1; r0_we = 1; r0_addr = 64'd10; r0_wdata = 64'h1000_0000_0000_0001;
    r1_req = 1; r1_we = 1; r1_addr = 64'd11; r1_wdata = 64'h2000_0000_0000_0001;
    for (int k = 0; k < 40 && got < 6; k++) begin
      @(negedge clk);
      if (r0_ack && r1_ack) chk("fair_double_ack", 64'd1, 64'd0);
      if (r0_ack || r1_ack) begin
        got++;
        if (exp_q.size() > 0) chk("fair_grant_order", {63'b0, r1_ack}, exp_q.pop_front());
        if (r0_ack) begin
          if (n0 == 3) r0_req = 0;
          else begin n0++; r0_wdata = r0_wdata + 1; end
        end else begin
          if (n1 == 3) r1_req = 0;
          else begin n1++; r1_wdata = r1_wdata + 1; end
        end
      end
    end
    chk("fair_count", 64'(got), 64'd6);
    r0_req = 0; r1_req = 0;
    @(negedge clk);
    watch_bus = 0;
    chk("fair_dm10", dm[10], 64'h1000_0000_0000_0003);
    chk("fair_dm11", dm[11], 64'h2000_0000_0000_0003);

    // Reset during the ACCESS cycle of a write, before the falling edge.
    r0_req = 1; r0_we = 1; r0_addr = 64'd9; r0_wdata = 64'hBAD0_BAD0_BAD0_BAD0;
    @(posedge clk);
    #1 rst = 0;
    #1;
    chk("rstmid_mem_rw", {63'b0, mem_rw}, 64'd0);
    chk("rstmid_bus_z", {63'b0, (mem_data === {DW{1'bz}}) || (mem_data === '0)}, 64'd1);
    chk("rstmid_no_ack", {62'b0, r1_ack, r0_ack}, 64'd0);
    chk("rstmid_state", 64'(dbg_state), 64'(ST_IDLE));
    r0_req = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    chk("rstmid_dm9_intact", dm[9], 64'h9999_0000_9999_0009);
    mem_drive_en = 1;
    @(negedge clk);
    r0_req = 1; r0_we = 0; r0_addr = 64'd9;
    r1_req = 1; r1_we = 0; r1_addr = 64'd7;
    first = 0; got = 0;
    for (int k = 0; k < 6 && got == 0; k++) begin
      @(negedge clk);
      if (r0_ack || r1_ack) begin got = 1; first = r1_ack; end
    end
    chk("rstmid_tie_seen", 64'(got), 64'd1);
    chk("rstmid_tie_winner", {63'b0, first}, {63'b0, REQ_R0});
    chk("rstmid_tie_rdata", r0_rdata, 64'h9999_0000_9999_0009);
    r0_req = 0; r1_req = 0;
    repeat (2) @(negedge clk);

    // r1 drops req during ACCESS of a read; the read still completes once.
    r1_req = 1; r1_we = 0; r1_addr = 64'd2;
    @(negedge clk);
    r1_req = 0; r1_addr = 64'd5;
    @(negedge clk);
    chk("drop_ack", {63'b0, r1_ack}, 64'd1);
    chk("drop_rdata", r1_rdata, 64'h0BAD_F00D_0000_0002);
    got = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (r1_ack || r0_ack) got++;
    end
    chk("drop_single_pulse", 64'(got), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
